matmul_weight_replay_buffer: RTL

Upstream stage for fixed_matmul_core on the weight (data_in2) path. It captures one weight tile stream of DEPTH beats, then replays it REPEAT times, so the matmul core can consume the same weights against REPEAT successive row blocks of data_in1. Single buffer, valid/ready on both sides, output read directly from the register array.

---
 rtl/matmul_weight_replay_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/matmul_weight_replay_buffer.sv
// ---------------------------------------------------------------------------
// matmul_weight_replay_buffer
//
// Weight-path staging buffer for fixed_matmul_core. Captures one weight tile
// of DEPTH beats, then replays that tile REPEAT times. The core can then
// consume the same weights against REPEAT successive row blocks of data_in1.
// There is one buffer and no overlap: input is refused while a replay is in
// progress.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : asynchronous active-low reset
//   data_in        : incoming weight beat, IN_SIZE*PARALLELISM elements
//   data_in_valid  : upstream beat valid
//   data_in_ready  : buffer accepts a beat (high only while filling)
//   data_out       : replayed weight beat, read straight from storage
//   data_out_valid : replayed beat valid (high only while replaying)
//   data_out_ready : core accepts the replayed beat
//   data_out_last  : current output beat is the final beat of a repetition
// ---------------------------------------------------------------------------
module matmul_weight_replay_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int IN_SIZE     = 3,
  parameter int PARALLELISM = 5,
  parameter int DEPTH       = 3,
  parameter int REPEAT      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_SIZE*PARALLELISM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [IN_SIZE*PARALLELISM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int N     = IN_SIZE * PARALLELISM;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPEAT - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [REP_W-1:0]      r_rep_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH][N];

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [PTR_W-1:0]      w_rd_inc;

  assign w_in_fire  = r_in_ready && data_in_valid;
  assign w_out_fire = r_out_valid && data_out_ready;
  assign w_rd_inc   = r_rd_ptr + 1'b1;

  assign data_in_ready  = r_in_ready;
  assign data_out_valid = r_out_valid;
  assign data_out_last  = r_out_last;

  // Storage is deliberately not reset; its contents only matter once a full
  // tile has been written.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int i = 0; i < N; i++) begin
        r_mem[r_wr_ptr][i] <= data_in[i];
      end
    end
  end

  // Output is a direct read of the addressed beat, so it holds for free
  // while rd_ptr holds during a stall.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_read
      assign data_out[gi] = r_mem[r_rd_ptr][gi];
    end
  endgenerate

  // Control FSM. The handshake flags are kept as registers updated together
  // with the state, so they change exactly when the state does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rep_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            if (r_wr_ptr == LAST_PTR) begin
              r_wr_ptr    <= '0;
              r_state     <= REPLAY;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              // rd_ptr is 0 here, which is the last beat only when DEPTH=1
              r_out_last  <= (LAST_PTR == '0);
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        REPLAY: begin
          if (w_out_fire) begin
            if (r_rd_ptr == LAST_PTR) begin
              r_rd_ptr   <= '0;
              r_out_last <= (LAST_PTR == '0);
              if (r_rep_cnt == LAST_REP) begin
                r_rep_cnt   <= '0;
                r_state     <= FILL;
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
              end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
              end
            end else begin
              r_rd_ptr   <= w_rd_inc;
              r_out_last <= (w_rd_inc == LAST_PTR);
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule
